doorlock_code_prog: RTL

Programming-side companion to the doorlock checker. It writes the stored 3-digit unlock code that the checker compares against. The user authenticates with the current code, enters a new code, and confirms it, all on the same three push buttons. On success the new code is committed to the code_d* outputs. Digit outputs feed the existing fnd decoder instances.

---
 rtl/doorlock_pkg.sv | 59 +++++
 rtl/bt_edge.sv | 25 ++
 rtl/doorlock_code_prog.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/doorlock_pkg.sv
// Shared definitions for the doorlock code path: phase encodings, digit widths,
// default code and small helpers for indexing a 3-digit code.
package doorlock_pkg;

  localparam int unsigned DIG_W   = 2;
  localparam int unsigned DISP_W  = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned PHASE_W = 3;

  localparam logic [DIG_W-1:0] DIG_BLANK   = 2'd0;
  localparam logic [DIG_W-1:0] DEF_CODE_D1 = 2'd2;
  localparam logic [DIG_W-1:0] DEF_CODE_D2 = 2'd1;
  localparam logic [DIG_W-1:0] DEF_CODE_D3 = 2'd3;
  localparam logic [IDX_W-1:0] IDX_LAST    = 2'd2;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE = 3'd0,
    PH_OLD  = 3'd1,
    PH_NEW  = 3'd2,
    PH_CNF  = 3'd3,
    PH_DONE = 3'd4,
    PH_ERR  = 3'd5
  } phase_e;

  typedef struct packed {
    logic [DIG_W-1:0] d1;
    logic [DIG_W-1:0] d2;
    logic [DIG_W-1:0] d3;
  } code_t;

  localparam code_t CODE_BLANK = '{d1: DIG_BLANK, d2: DIG_BLANK, d3: DIG_BLANK};

  // Digit at position i (0-based); index 3 never occurs and aliases digit 3.
  function automatic logic [DIG_W-1:0] code_digit(code_t c, logic [IDX_W-1:0] i);
    logic [DIG_W-1:0] r;
    case (i)
      2'd0:    r = c.d1;
      2'd1:    r = c.d2;
      default: r = c.d3;
    endcase
    return r;
  endfunction

  function automatic code_t code_set(code_t c, logic [IDX_W-1:0] i, logic [DIG_W-1:0] v);
    code_t r;
    r = c;
    case (i)
      2'd0:    r.d1 = v;
      2'd1:    r.d2 = v;
      default: r.d3 = v;
    endcase
    return r;
  endfunction

  function automatic logic [DISP_W-1:0] to_disp(logic [DIG_W-1:0] v);
    return DISP_W'(v);
  endfunction

endpackage

// File: rtl/bt_edge.sv
// Two-flop synchronizer for an active-low push button with a one-cycle press
// pulse on the synchronized falling edge. Flops reset to released (1).
module bt_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic bt,
  output logic press_c
);

  logic d1;
  logic d2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d1 <= 1'b1;
      d2 <= 1'b1;
    end else begin
      d1 <= bt;
      d2 <= d1;
    end
  end

  assign press_c = ~d1 & d2;

endmodule

// File: rtl/doorlock_code_prog.sv
// Programs the stored 3-digit unlock code: authenticate with the current code,
// enter a new one, confirm it, and commit on a matching confirmation.
module doorlock_code_prog
  import doorlock_pkg::*;
#(
  parameter logic [DIG_W-1:0] DEF_D1 = DEF_CODE_D1,
  parameter logic [DIG_W-1:0] DEF_D2 = DEF_CODE_D2,
  parameter logic [DIG_W-1:0] DEF_D3 = DEF_CODE_D3
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               bt_1,
  input  logic               bt_2,
  input  logic               bt_3,
  input  logic               prog_en,
  output logic [DIG_W-1:0]   code_d1,
  output logic [DIG_W-1:0]   code_d2,
  output logic [DIG_W-1:0]   code_d3,
  output logic [DISP_W-1:0]  dig_1,
  output logic [DISP_W-1:0]  dig_2,
  output logic [DISP_W-1:0]  dig_3,
  output logic               led_ok,
  output logic               led_err,
  output logic [PHASE_W-1:0] prog_state,
  output logic [IDX_W-1:0]   prog_idx
);

  localparam code_t CODE_DEF = '{d1: DEF_D1, d2: DEF_D2, d3: DEF_D3};

  logic p1_c;
  logic p2_c;
  logic p3_c;
  logic press_c;
  logic [DIG_W-1:0] press_val_c;

  bt_edge u_bt_1 (.clk(clk), .n_rst(n_rst), .bt(bt_1), .press_c(p1_c));
  bt_edge u_bt_2 (.clk(clk), .n_rst(n_rst), .bt(bt_2), .press_c(p2_c));
  bt_edge u_bt_3 (.clk(clk), .n_rst(n_rst), .bt(bt_3), .press_c(p3_c));

  // Simultaneous presses collapse into one digit, lowest button wins.
  always_comb begin
    press_c     = p1_c | p2_c | p3_c;
    press_val_c = DIG_BLANK;
    if (p1_c)      press_val_c = 2'd1;
    else if (p2_c) press_val_c = 2'd2;
    else if (p3_c) press_val_c = 2'd3;
  end

  phase_e           phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             match_q, match_d;
  code_t            pend_q, pend_d;
  code_t            code_q, code_d;
  code_t            dig_q, dig_d;
  logic             last_c;
  logic             hit_c;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q <= PH_IDLE;
      idx_q   <= '0;
      match_q <= 1'b0;
      pend_q  <= CODE_BLANK;
      code_q  <= CODE_DEF;
      dig_q   <= CODE_BLANK;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      dig_q   <= dig_d;
    end
  end

  // Sequencing: every phase collects exactly three digits before deciding.
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    match_d = match_q;
    pend_d  = pend_q;
    code_d  = code_q;
    dig_d   = dig_q;
    last_c  = (idx_q == IDX_LAST);
    hit_c   = 1'b0;

    if (!prog_en) begin
      phase_d = PH_IDLE;
      idx_d   = '0;
      pend_d  = CODE_BLANK;
      dig_d   = CODE_BLANK;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          phase_d = PH_OLD;
          idx_d   = '0;
          match_d = 1'b1;
          dig_d   = CODE_BLANK;
        end
        PH_OLD: begin
          if (press_c) begin
            hit_c = match_q && (press_val_c == code_digit(code_q, idx_q));
            dig_d = code_set(dig_q, idx_q, press_val_c);
            if (last_c) begin
              phase_d = hit_c ? PH_NEW : PH_ERR;
              idx_d   = '0;
              match_d = 1'b1;
              dig_d   = CODE_BLANK;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              match_d = hit_c;
            end
          end
        end
        PH_NEW: begin
          if (press_c) begin
            pend_d = code_set(pend_q, idx_q, press_val_c);
            dig_d  = code_set(dig_q, idx_q, press_val_c);
            if (last_c) begin
              phase_d = PH_CNF;
              idx_d   = '0;
              match_d = 1'b1;
              dig_d   = CODE_BLANK;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        PH_CNF: begin
          if (press_c) begin
            hit_c = match_q && (press_val_c == code_digit(pend_q, idx_q));
            dig_d = code_set(dig_q, idx_q, press_val_c);
            if (last_c) begin
              idx_d = '0;
              if (hit_c) begin
                phase_d = PH_DONE;
                code_d  = pend_q;
                dig_d   = pend_q;
              end else begin
                phase_d = PH_ERR;
                dig_d   = CODE_BLANK;
              end
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              match_d = hit_c;
            end
          end
        end
        PH_DONE, PH_ERR: begin
          phase_d = phase_q;
        end
        default: begin
          phase_d = PH_IDLE;
          idx_d   = '0;
          pend_d  = CODE_BLANK;
          dig_d   = CODE_BLANK;
        end
      endcase
    end
  end

  assign code_d1    = code_q.d1;
  assign code_d2    = code_q.d2;
  assign code_d3    = code_q.d3;
  assign dig_1      = to_disp(dig_q.d1);
  assign dig_2      = to_disp(dig_q.d2);
  assign dig_3      = to_disp(dig_q.d3);
  assign led_ok     = (phase_q == PH_DONE);
  assign led_err    = (phase_q == PH_ERR);
  assign prog_state = phase_q;
  assign prog_idx   = idx_q;

endmodule
